// File: rtl/mem_loader.sv
// Burst loader that takes ownership of a 16 x 8 memory, writes host bytes
// one at a time, and reads each byte back to flag any mismatch.
module mem_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_start,
    input  logic [3:0] start_addr,
    input  logic [4:0] count,
    input  logic       abort,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic       data_ready,
    input  logic [7:0] mem_out,
    output logic       SEL,
    output logic [3:0] manual_addr,
    output logic [7:0] manual_value,
    output logic       manual_WE,
    output logic       cpu_halt,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0] state_reg, state_next;
    logic [3:0] addr_reg, addr_next;
    logic [4:0] remain_reg, remain_next;
    logic [7:0] value_reg, value_next;
    logic       error_reg, error_next;
    logic       sel_reg, sel_next;
    logic       ready_reg, ready_next;
    logic       we_reg, we_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    // Next-state and datapath decisions; every output is a register loaded
    // from a decode of the next state, so nothing combinational leaves the block.
    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        remain_next = remain_reg;
        value_next  = value_reg;
        error_next  = error_reg;

        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    error_next = 1'b0;
                    if (count != 5'd0) begin
                        addr_next   = start_addr;
                        remain_next = count;
                        state_next  = ST_ARM;
                    end else begin
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_ARM: begin
                state_next = abort ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // abort wins over a simultaneous handshake: the byte is dropped
                if (abort) begin
                    state_next = ST_DONE;
                end else if (data_valid) begin
                    value_next = data_in;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // the write strobe is already out this cycle, so it completes
                state_next = abort ? ST_DONE : ST_CHECK;
            end
            ST_CHECK: begin
                if (mem_out != value_reg) begin
                    error_next = 1'b1;
                end
                addr_next   = addr_reg + 4'd1;
                remain_next = remain_reg - 5'd1;
                state_next  = (abort || remain_reg == 5'd1) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        ready_next = (state_next == ST_WAIT);
        we_next    = (state_next == ST_WRITE);
        busy_next  = (state_next != ST_IDLE);
        done_next  = (state_next == ST_DONE);

        // memory ownership is taken on the way into ARM and released in IDLE;
        // a zero-length burst goes IDLE -> DONE and never claims the memory
        if (state_next == ST_ARM) begin
            sel_next = 1'b1;
        end else if (state_next == ST_IDLE) begin
            sel_next = 1'b0;
        end else begin
            sel_next = sel_reg;
        end
    end

    // State, counters and registered outputs; reset clears everything at once
    // so a write strobe in flight is withdrawn before the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= 4'd0;
            remain_reg <= 5'd0;
            value_reg  <= 8'd0;
            error_reg  <= 1'b0;
            sel_reg    <= 1'b0;
            ready_reg  <= 1'b0;
            we_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            remain_reg <= remain_next;
            value_reg  <= value_next;
            error_reg  <= error_next;
            sel_reg    <= sel_next;
            ready_reg  <= ready_next;
            we_reg     <= we_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign data_ready   = ready_reg;
    assign SEL          = sel_reg;
    assign cpu_halt     = sel_reg;
    assign manual_addr  = addr_reg;
    assign manual_value = value_reg;
    assign manual_WE    = we_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign error        = error_reg;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: table of bursts plus hand-built corner sequences,
// with a write scoreboard fed at each handshake and drained on each strobe.
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic [3:0] start_addr;
    logic [4:0] count;
    logic       abort;
    logic       data_valid;
    logic [7:0] data_in;
    logic       data_ready;
    logic [7:0] mem_out;
    logic       SEL;
    logic [3:0] manual_addr;
    logic [7:0] manual_value;
    logic       manual_WE;
    logic       cpu_halt;
    logic       busy;
    logic       done;
    logic       error;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  mem [16];
    logic        force_zero = 1'b0;
    logic [11:0] exp_q [$];

    mem_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .start_addr(start_addr),
        .count(count), .abort(abort), .data_valid(data_valid), .data_in(data_in),
        .data_ready(data_ready), .mem_out(mem_out), .SEL(SEL),
        .manual_addr(manual_addr), .manual_value(manual_value),
        .manual_WE(manual_WE), .cpu_halt(cpu_halt), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // memory model: combinational read, write on the edge while owned
    assign mem_out = force_zero ? 8'h00 : mem[manual_addr];
    always @(posedge clk) begin
        if (manual_WE && SEL) mem[manual_addr] <= manual_value;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard drain: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (manual_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         manual_addr, manual_value);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("sb_write", {manual_addr, manual_value}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // entered in WAIT; performs one handshake and follows it to the next WAIT/DONE
    task automatic send_byte(input logic [3:0] a, input logic [7:0] d, input logic last);
        data_valid = 1'b1;
        data_in    = d;
        chk("wait_ready", data_ready, 1'b1);
        exp_q.push_back({a, d});
        step();
        chk("write_we", manual_WE, 1'b1);
        chk("write_addr", manual_addr, a);
        chk("write_ready", data_ready, 1'b0);
        $display("byte addr=%0h data=%02h written", a, d);
        step();
        chk("check_we", manual_WE, 1'b0);
        step();
        if (last) chk("done_pulse", done, 1'b1);
        else      chk("ready_again", data_ready, 1'b1);
    endtask

    task automatic run_burst(input logic [3:0] sa, input logic [4:0] cnt, input logic [7:0] base,
                             input logic fz, input logic exp_err);
        logic [3:0] a;
        a = sa;
        force_zero = fz;
        load_start = 1'b1;
        start_addr = sa;
        count      = cnt;
        step();
        load_start = 1'b0;
        chk("arm_sel", SEL, 1'b1);
        chk("arm_halt", cpu_halt, 1'b1);
        chk("arm_ready", data_ready, 1'b0);
        chk("arm_err", error, 1'b0);
        step();
        for (int i = 0; i < int'(cnt); i++) begin
            send_byte(a, base + 8'(i), i == int'(cnt) - 1);
            a = a + 4'd1;
        end
        chk("done_sel", SEL, 1'b1);
        chk("done_err", error, exp_err);
        data_valid = 1'b0;
        force_zero = 1'b0;
        step();
        chk("idle_sel", SEL, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_addr", manual_addr, a);
        chk("idle_err", error, exp_err);
        step();
        chk("idle_err_hold", error, exp_err);
        if (!fz) begin
            for (int i = 0; i < int'(cnt); i++)
                chk("mem_content", mem[(int'(sa) + i) % 16], base + 8'(i));
        end
        $display("burst sa=%0h cnt=%0d end_addr=%0h error=%0b", sa, cnt, manual_addr, error);
    endtask

    typedef struct {
        logic [3:0] sa;
        logic [4:0] cnt;
        logic [7:0] base;
        logic       fz;
        logic       err;
    } burst_t;

    burst_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'd0,  5'd16, 8'h10, 1'b0, 1'b0};  // full load
        tbl[1] = '{4'd14, 5'd4,  8'hA1, 1'b0, 1'b0};  // wrap
        tbl[2] = '{4'd5,  5'd1,  8'h77, 1'b0, 1'b0};
        tbl[3] = '{4'd9,  5'd3,  8'hC0, 1'b0, 1'b0};
        tbl[4] = '{4'd3,  5'd1,  8'h55, 1'b1, 1'b1};  // forced readback mismatch
        tbl[5] = '{4'd7,  5'd1,  8'h66, 1'b0, 1'b0};  // clears the error

        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
        rst = 1'b0; load_start = 1'b0; start_addr = 4'd0; count = 5'd0;
        abort = 1'b0; data_valid = 1'b0; data_in = 8'd0;
        #12;
        chk("rst_sel", SEL, 1'b0);
        chk("rst_we", manual_WE, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", manual_addr, 4'd0);
        chk("rst_value", manual_value, 8'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ready", data_ready, 1'b0);

        for (int i = 0; i < 6; i++)
            run_burst(tbl[i].sa, tbl[i].cnt, tbl[i].base, tbl[i].fz, tbl[i].err);

        // stall then abort with a simultaneous valid byte
        load_start = 1'b1; start_addr = 4'd4; count = 5'd5;
        step(); load_start = 1'b0;
        step();
        send_byte(4'd4, 8'hE1, 1'b0);
        send_byte(4'd5, 8'hE2, 1'b0);
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_ready", data_ready, 1'b1);
        end
        abort = 1'b1; data_valid = 1'b1; data_in = 8'hEE;
        step();
        chk("abort_done", done, 1'b1);
        chk("abort_we", manual_WE, 1'b0);
        abort = 1'b0; data_valid = 1'b0;
        step();
        chk("abort_sel_drop", SEL, 1'b0);
        chk("abort_addr", manual_addr, 4'd6);
        $display("stall/abort end_addr=%0h", manual_addr);

        // zero count and load_start ignored while busy
        run_burst(4'd10, 5'd1, 8'h5A, 1'b0, 1'b0);
        load_start = 1'b1; start_addr = 4'd9; count = 5'd0;
        step(); load_start = 1'b0;
        chk("zero_done", done, 1'b1);
        chk("zero_sel", SEL, 1'b0);
        chk("zero_we", manual_WE, 1'b0);
        chk("zero_addr", manual_addr, 4'd11);
        step();
        chk("zero_idle", busy, 1'b0);
        load_start = 1'b1; start_addr = 4'd2; count = 5'd2;
        step();
        start_addr = 4'd11; count = 5'd1;  // still asserted during ARM
        step(); load_start = 1'b0;
        chk("ignored_addr", manual_addr, 4'd2);
        send_byte(4'd2, 8'hD1, 1'b0);
        send_byte(4'd3, 8'hD2, 1'b1);
        data_valid = 1'b0;
        step();
        chk("ignored_end", manual_addr, 4'd4);
        $display("zero/ignored end_addr=%0h", manual_addr);

        // abort in IDLE ignored, abort in WRITE lets the write finish
        load_start = 1'b1; abort = 1'b1; start_addr = 4'd0; count = 5'd3;
        step(); load_start = 1'b0; abort = 1'b0;
        chk("idle_abort_arm", SEL, 1'b1);
        chk("idle_abort_done", done, 1'b0);
        step();
        data_valid = 1'b1; data_in = 8'hB1;
        exp_q.push_back({4'd0, 8'hB1});
        step();
        chk("wabort_we", manual_WE, 1'b1);
        abort = 1'b1; data_valid = 1'b0;
        step();
        chk("wabort_done", done, 1'b1);
        chk("wabort_addr", manual_addr, 4'd0);
        abort = 1'b0;
        step();
        chk("wabort_idle", busy, 1'b0);
        chk("wabort_mem", mem[0], 8'hB1);
        $display("write-abort mem0=%02h", mem[0]);

        // reset during WRITE
        load_start = 1'b1; start_addr = 4'd8; count = 5'd2;
        step(); load_start = 1'b0;
        step();
        data_valid = 1'b1; data_in = 8'h99;
        step();
        data_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_we", manual_WE, 1'b0);
        chk("mid_rst_sel", SEL, 1'b0);
        chk("mid_rst_halt", cpu_halt, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_addr", manual_addr, 4'd0);
        chk("mid_rst_value", manual_value, 8'd0);
        @(posedge clk); #1;
        chk("mid_rst_no_write", mem[8], 8'h18);
        rst = 1'b1;
        step();
        chk("rel_busy", busy, 1'b0);
        chk("rel_sel", SEL, 1'b0);
        run_burst(4'd12, 5'd1, 8'h3C, 1'b0, 1'b0);

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have no parameters; the memory size is fixed at 16 x 8 bits with a 4-bit address.
REQ-002 SHALL have port `clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port `load_start`, input, 1 bit: request for a load burst; sampled in IDLE only.
REQ-005 SHALL have port `start_addr`, input, 4 bits: first memory address of the burst; sampled with `load_start`.
REQ-006 SHALL have port `count`, input, 5 bits: number of bytes in the burst, 0..16; sampled with `load_start`.
REQ-007 SHALL have port `abort`, input, 1 bit: terminate the burst early.
REQ-008 SHALL have port `data_valid`, input, 1 bit: host byte valid.
REQ-009 SHALL have port `data_in`, input, 8 bits: host byte.
REQ-010 SHALL have port `data_ready`, output, 1 bit: block accepts a byte this cycle.
REQ-011 SHALL have port `mem_out`, input, 8 bits: combinational read data from the memory.
REQ-012 SHALL have port `SEL`, output, 1 bit: memory source select (1 = this block, 0 = CPU bus).
REQ-013 SHALL have port `manual_addr`, output, 4 bits: memory address driven to the memory.
REQ-014 SHALL have port `manual_value`, output, 8 bits: write data driven to the memory.
REQ-015 SHALL have port `manual_WE`, output, 1 bit: memory write strobe.
REQ-016 SHALL have port `cpu_halt`, output, 1 bit: freezes the CPU while the memory is owned.
REQ-017 SHALL have port `busy`, output, 1 bit: 1 in every state except IDLE.
REQ-018 SHALL have port `done`, output, 1 bit: one-cycle pulse at the end of a burst.
REQ-019 SHALL have port `error`, output, 1 bit: sticky readback-mismatch flag.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 States SHALL be IDLE, ARM, WAIT, WRITE, CHECK, DONE.
REQ-022 IDLE: when `load_start`=1 and `count`!=0, the block SHALL latch `start_addr` into the address counter and `count` into the remaining counter, clear `error`, and go to ARM.
REQ-023 IDLE: `load_start` with `count`=0 SHALL go directly to DONE with no write.
REQ-024 ARM SHALL last exactly one cycle with `SEL`=1 and `cpu_halt`=1, then go to WAIT.
  - This provides one settle cycle before any write.
REQ-025 `SEL` and `cpu_halt` SHALL be 1 in ARM, WAIT, WRITE, CHECK and DONE, and 0 in IDLE.
REQ-026 WAIT SHALL drive `data_ready`=1; `data_ready` SHALL be 0 in all other states.
REQ-027 A handshake SHALL occur when `data_valid`=1 and `data_ready`=1 on the same edge.
  - Effect: capture `data_in` into `manual_value`; go to WRITE.
REQ-028 WRITE SHALL drive `manual_WE`=1 for exactly one cycle with `manual_addr`=address counter, then go to CHECK.
  - `manual_WE` SHALL be 0 in every other state.
REQ-029 CHECK: if `mem_out` != `manual_value`, `error` SHALL be set to 1.
REQ-030 CHECK SHALL then increment the address counter modulo 16 (15 wraps to 0) and decrement the remaining counter.
REQ-031 CHECK SHALL go to DONE if the remaining counter was 1, else to WAIT.
REQ-032 Per-byte latency SHALL be: handshake at edge N, write edge N+1, check edge N+2, `data_ready`=1 again in cycle N+3.
REQ-033 DONE SHALL last one cycle with `done`=1, then go to IDLE, where `SEL` and `cpu_halt` drop.
REQ-034 `abort`=1 in ARM, WAIT or CHECK SHALL go to DONE on the next edge, skipping the remaining bytes.
REQ-035 `abort` in WRITE SHALL let that write complete, then go to DONE instead of CHECK.
REQ-036 `abort` in IDLE or DONE SHALL be ignored.
REQ-037 `abort` SHALL have priority over a simultaneous handshake in WAIT; the byte is not accepted.
REQ-038 `load_start` while `busy`=1 SHALL be ignored.
REQ-039 `error` SHALL hold until the next accepted `load_start` or reset.
REQ-040 `manual_addr` SHALL always equal the address counter.

Reset
REQ-041 While `rst`=0, the block SHALL asynchronously force state IDLE.
  - All outputs 0: `SEL`, `cpu_halt`, `manual_WE`, `data_ready`, `busy`, `done`, `error`.
  - `manual_addr`=0, `manual_value`=0, remaining counter 0.
REQ-042 Reset mid-burst SHALL drop `manual_WE` and `SEL` immediately; no partial write SHALL occur after `rst` falls.
REQ-043 The first state change after reset release SHALL happen no earlier than the first rising edge of `clk` with `rst`=1.

Verification
REQ-044 Full load: `start_addr`=0, `count`=16, bytes 0x10..0x1F with `data_valid` held high.
  - Required: 16 `manual_WE` pulses at addresses 0..15, one every 3 cycles.
  - Required: `done` 3 cycles after the last handshake; `error`=0; memory holds 0x10..0x1F.
REQ-045 Wrap: `start_addr`=14, `count`=4, bytes A1,A2,A3,A4.
  - Required: writes to addresses 14, 15, 0, 1; `manual_addr`=2 after DONE.
REQ-046 Stall and abort: `count`=5, host sends 2 bytes, idles 10 cycles, then asserts `abort` together with `data_valid`.
  - Required: exactly 2 writes; third byte not accepted; `done` pulse; `SEL`=0 the cycle after DONE.
REQ-047 Mismatch: memory model forces `mem_out`=0x00 in CHECK for byte 0x55.
  - Required: `error`=1 and held through DONE and IDLE.
  - Required: cleared by the next `load_start` with `count`=1.
REQ-048 Zero count and ignored start: `load_start` with `count`=0, then `load_start` pulsed while `busy`.
  - Required: first gives `done` 1 cycle later with no `manual_WE` and no `SEL`; second has no effect on the counters.
REQ-049 Reset mid-write: drive `rst`=0 asynchronously during WRITE.
  - Required: all outputs 0 before the next clock edge; block in IDLE after release.
